// File: rtl/boot_loader.sv
// boot_loader: receives a program image as a byte stream, writes it word by
// word into instruction memory, verifies an XOR checksum, then releases the
// CPU from reset and counts the cycles it runs until it halts.
//
// Image format: count N (2 bytes, big-endian), N words (4 bytes each,
// big-endian), 1 checksum byte = XOR of every preceding byte.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx_valid   byte available on rx_byte
//   rx_byte    incoming image byte
//   rx_ready   loader accepts a byte (low only while the CPU runs)
//   imem_we    one-cycle instruction-memory write strobe
//   imem_addr  instruction-memory word address
//   imem_wdata instruction word
//   cpu_rst_n  active-low CPU reset, registered
//   cpu_hlt    CPU halt, only observed while the CPU runs
//   done       CPU halted after a verified load
//   err        load failed
//   err_code   01 timeout, 10 checksum mismatch, 11 count overflow
//   run_cycles clock cycles the CPU spent released (saturating)
module boot_loader #(
  parameter logic [21:0] BASE_ADDR = 22'h000000,
  parameter int unsigned MEM_WORDS = 16384,
  parameter int unsigned TIMEOUT   = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [21:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst_n,
  input  logic        cpu_hlt,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] run_cycles
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MEM_LIMIT = 17'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE, CNT_LO, DATA, CSUM, RUN, DONE, ERR
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    err_code_nxt;
  logic [15:0]   count;
  logic [15:0]   word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   asm_word;
  logic [7:0]    xsum;
  logic [TW-1:0] tmo_cnt;
  logic          accept;
  logic          tmo_expire;
  logic          last_word;
  logic [16:0]   n_ext;

  assign rx_ready   = (state != RUN);
  assign accept     = rx_valid && rx_ready;
  assign done       = (state == DONE);
  assign err        = (state == ERR);
  assign tmo_expire = (tmo_cnt == TW'(TIMEOUT - 1));
  assign last_word  = (word_idx == count - 16'd1);
  assign n_ext      = {1'b0, count[15:8], rx_byte};

  always_comb begin
    state_nxt    = state;
    err_code_nxt = err_code;
    case (state)
      IDLE, DONE, ERR: begin
        if (accept) begin
          state_nxt    = CNT_LO;
          err_code_nxt = '0;
        end
      end
      CNT_LO: begin
        if (accept) begin
          if (n_ext > MEM_LIMIT) begin
            state_nxt    = ERR;
            err_code_nxt = 2'b11;
          end else if (n_ext == '0) begin
            state_nxt = CSUM;
          end else begin
            state_nxt = DATA;
          end
        end else if (tmo_expire) begin
          state_nxt    = ERR;
          err_code_nxt = 2'b01;
        end
      end
      DATA: begin
        if (accept) begin
          if (byte_idx == 2'd3 && last_word) state_nxt = CSUM;
        end else if (tmo_expire) begin
          state_nxt    = ERR;
          err_code_nxt = 2'b01;
        end
      end
      CSUM: begin
        if (accept) begin
          if (rx_byte == xsum) begin
            state_nxt = RUN;
          end else begin
            state_nxt    = ERR;
            err_code_nxt = 2'b10;
          end
        end else if (tmo_expire) begin
          state_nxt    = ERR;
          err_code_nxt = 2'b01;
        end
      end
      RUN: begin
        if (cpu_hlt) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      err_code  <= '0;
    end else begin
      state     <= state_nxt;
      err_code  <= err_code_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rst_n  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      run_cycles <= '0;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      asm_word   <= '0;
      xsum       <= '0;
      tmo_cnt    <= '0;
    end else begin
      imem_we   <= 1'b0;
      // Decoding the next state keeps the CPU reset glitch-free and makes
      // the release land exactly one cycle after the checksum byte.
      cpu_rst_n <= (state_nxt == RUN) || (state_nxt == DONE);

      if (accept)
        tmo_cnt <= '0;
      else if (state == CNT_LO || state == DATA || state == CSUM)
        tmo_cnt <= tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;

      case (state)
        IDLE, DONE, ERR: begin
          if (accept) begin
            count      <= {rx_byte, 8'h00};
            xsum       <= rx_byte;
            word_idx   <= '0;
            byte_idx   <= '0;
            run_cycles <= '0;
          end
        end
        CNT_LO: begin
          if (accept) begin
            count[7:0] <= rx_byte;
            xsum       <= xsum ^ rx_byte;
          end
        end
        DATA: begin
          if (accept) begin
            xsum     <= xsum ^ rx_byte;
            asm_word <= {asm_word[15:0], rx_byte};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {asm_word, rx_byte};
              imem_addr  <= BASE_ADDR + 22'(word_idx);
              word_idx   <= word_idx + 16'd1;
            end
          end
        end
        RUN: begin
          if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
